// File: rtl/ila_scan_checker_pkg.sv
// Shared types for the ILA scan checker: reset level, scan mode, FSM states
// and the default-sized observed-state array.
package common;

  localparam logic RESET     = 1'b0;
  localparam int   ILA_DEPTH = 32;
  localparam int   ILA_WIDTH = 32;

  typedef enum logic {
    STOP_FIRST = 1'b0,
    FULL_SCAN  = 1'b1
  } ila_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } ila_state_e;

  typedef logic [ILA_DEPTH-1:0][ILA_WIDTH-1:0] ila_array_t;

endpackage

// File: rtl/ila_scan_checker_if.sv
// Control, expected-table load, observed-state and result signals of the
// scan checker. master drives requests; slave is the checker side.
interface ila_scan_checker_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) ();
  import common::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                         start;
  ila_mode_e                    mode;
  logic                         exp_we;
  logic [AW-1:0]                exp_addr;
  logic [WIDTH-1:0]             exp_data;
  logic [WIDTH-1:0]             exp_mask;
  logic [DEPTH-1:0][WIDTH-1:0]  obs_array;

  logic                         busy;
  logic                         done;
  logic                         ok;
  logic [CW-1:0]                err_count;
  logic [AW-1:0]                fail_idx;
  logic [WIDTH-1:0]             fail_obs;
  logic [WIDTH-1:0]             fail_exp;

  modport master (
    output start, mode, exp_we, exp_addr, exp_data, exp_mask, obs_array,
    input  busy, done, ok, err_count, fail_idx, fail_obs, fail_exp
  );

  modport slave (
    input  start, mode, exp_we, exp_addr, exp_data, exp_mask, obs_array,
    output busy, done, ok, err_count, fail_idx, fail_obs, fail_exp
  );

endinterface

// File: rtl/ila_scan_checker_lane_cmp.sv
// Combinational masked compare of one group of LANES entries: hit vector,
// hit count, and the offset/values of the lowest-numbered hit.
module ila_lane_cmp #(
  parameter int LANES = 1,
  parameter int WIDTH = 32,
  localparam int HC_W  = $clog2(LANES + 1),
  localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0][WIDTH-1:0] obs_i,
  input  logic [LANES-1:0][WIDTH-1:0] exp_i,
  input  logic [LANES-1:0][WIDTH-1:0] mask_i,
  input  logic                        skip_first_i,
  output logic [LANES-1:0]            hit_vec_o,
  output logic [HC_W-1:0]             hit_cnt_o,
  output logic [OFF_W-1:0]            low_off_o,
  output logic [WIDTH-1:0]            low_obs_o,
  output logic [WIDTH-1:0]            low_exp_o
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_hit
    if (gi == 0) begin : g_first
      assign hit_vec_o[gi] = (((obs_i[gi] ^ exp_i[gi]) & mask_i[gi]) != '0) && !skip_first_i;
    end else begin : g_rest
      assign hit_vec_o[gi] = ((obs_i[gi] ^ exp_i[gi]) & mask_i[gi]) != '0;
    end
  end

  // Walk downwards so the last assignment wins with the lowest hit offset.
  always_comb begin
    hit_cnt_o = '0;
    low_off_o = '0;
    low_obs_o = '0;
    low_exp_o = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (hit_vec_o[l]) begin
        hit_cnt_o = hit_cnt_o + HC_W'(1);
        low_off_o = OFF_W'(l);
        low_obs_o = obs_i[l];
        low_exp_o = exp_i[l];
      end
    end
  end

endmodule

// File: rtl/ila_scan_checker.sv
// Scans an observed register file / memory against a masked expected table,
// LANES entries per cycle, reporting mismatch count and the first mismatch.
module ila_scan_checker
  import common::*;
#(
  parameter int DEPTH     = 32,
  parameter int WIDTH     = 32,
  parameter int LANES     = 1,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  ila_scan_checker_if.slave bus
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int GROUPS = DEPTH / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int HC_W   = $clog2(LANES + 1);
  localparam int OFF_W  = (LANES > 1) ? $clog2(LANES) : 1;

  ila_state_e        state_q, state_d;
  ila_mode_e         mode_q, mode_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [CW-1:0]     err_q, err_d;
  logic [AW-1:0]     fidx_q, fidx_d;
  logic [WIDTH-1:0]  fobs_q, fobs_d;
  logic [WIDTH-1:0]  fexp_q, fexp_d;

  logic [WIDTH-1:0]  exp_q  [DEPTH];
  logic [WIDTH-1:0]  mask_q [DEPTH];

  logic [AW-1:0]                 base_idx;
  logic [LANES-1:0][WIDTH-1:0]   obs_grp, exp_grp, mask_grp;
  logic [LANES-1:0]              hit_vec;
  logic [HC_W-1:0]               hit_cnt;
  logic [OFF_W-1:0]              low_off;
  logic [WIDTH-1:0]              low_obs, low_exp;
  logic                          any_hit;

  // Table writes are only accepted outside SCAN so a running scan sees a stable table.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_q[i]  <= '0;
        mask_q[i] <= '1;
      end
    end else if (bus.exp_we && (state_q != SCAN)) begin
      exp_q[bus.exp_addr]  <= bus.exp_data;
      mask_q[bus.exp_addr] <= bus.exp_mask;
    end
  end

  assign base_idx = AW'(grp_q) << $clog2(LANES);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx          = base_idx + AW'(gi);
    assign obs_grp[gi]  = bus.obs_array[idx];
    assign exp_grp[gi]  = exp_q[idx];
    assign mask_grp[gi] = mask_q[idx];
  end

  ila_lane_cmp #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_lane_cmp (
    .obs_i        (obs_grp),
    .exp_i        (exp_grp),
    .mask_i       (mask_grp),
    .skip_first_i (SKIP_ZERO && (grp_q == '0)),
    .hit_vec_o    (hit_vec),
    .hit_cnt_o    (hit_cnt),
    .low_off_o    (low_off),
    .low_obs_o    (low_obs),
    .low_exp_o    (low_exp)
  );

  assign any_hit = |hit_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      state_q <= IDLE;
      mode_q  <= STOP_FIRST;
      grp_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fobs_q  <= '0;
      fexp_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      grp_q   <= grp_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fobs_q  <= fobs_d;
      fexp_q  <= fexp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    grp_d   = grp_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fobs_d  = fobs_q;
    fexp_d  = fexp_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SCAN;
          mode_d  = bus.mode;
          grp_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
          fobs_d  = '0;
          fexp_d  = '0;
        end
      end
      SCAN: begin
        if (any_hit) begin
          // err_q still zero means this group holds the scan's first mismatch.
          if (err_q == '0) begin
            fidx_d = base_idx + AW'(low_off);
            fobs_d = low_obs;
            fexp_d = low_exp;
          end
          if (mode_q == STOP_FIRST) begin
            err_d = CW'(1);
          end else begin
            err_d = err_q + CW'(hit_cnt);
          end
        end
        if ((grp_q == GW'(GROUPS - 1)) || ((mode_q == STOP_FIRST) && any_hit)) begin
          state_d = DONE;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.ok        = (state_q == DONE) && (err_q == '0);
  assign bus.err_count = err_q;
  assign bus.fail_idx  = fidx_q;
  assign bus.fail_obs  = fobs_q;
  assign bus.fail_exp  = fexp_q;

endmodule
